// File: rtl/layer_loader_if.sv
// Stream-in and layer-write signal bundle for layer_loader.
// Valid/ready: a word transfers on a rising edge where in_valid && in_ready; the host holds in_data stable while in_valid is high and not yet accepted.
interface layer_loader_if #(
    parameter int DATA_SIZE = 64
);
    logic [DATA_SIZE-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] write_data;
    logic [15:0]          index3;
    logic [15:0]          index2;
    logic [15:0]          index1;
    logic [15:0]          index0;
    logic                 want_write_weights;
    logic                 want_write_bias;
    logic                 want_write_act;
    logic                 compute;
    logic                 layer_done;

    // Host / layer side.
    modport master (
        output in_data, in_valid, layer_done,
        input  in_ready, write_data, index3, index2, index1, index0,
               want_write_weights, want_write_bias, want_write_act, compute
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid, layer_done,
        output in_ready, write_data, index3, index2, index1, index0,
               want_write_weights, want_write_bias, want_write_act, compute
    );
endinterface

// File: rtl/layer_loader.sv
// Turns a valid/ready word stream into a conv layer's indexed weight/bias/activation
// writes, then fires the layer and waits for its output_valid.
module layer_loader #(
    parameter int DATA_SIZE   = 64,
    parameter int NUM_INPUTS  = 1,
    parameter int INPUT_DIM   = 28,
    parameter int NUM_OUTPUTS = 16,
    parameter int KERNEL_DIM  = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    layer_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_B = 3'd2,
        S_LOAD_A = 3'd3,
        S_FIRE   = 3'd4,
        S_WAIT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [15:0] W_LAST = 16'(NUM_OUTPUTS * NUM_INPUTS * KERNEL_DIM * KERNEL_DIM - 1);
    localparam logic [15:0] B_LAST = 16'(NUM_OUTPUTS - 1);
    localparam logic [15:0] A_LAST = 16'(NUM_INPUTS * INPUT_DIM * INPUT_DIM - 1);
    localparam logic [15:0] K_MAX  = 16'(KERNEL_DIM - 1);
    localparam logic [15:0] D_MAX  = 16'(INPUT_DIM - 1);
    localparam logic [15:0] I_MAX  = 16'(NUM_INPUTS - 1);

    state_t      state;
    logic [15:0] word_cnt;
    logic [15:0] col;
    logic [15:0] row;
    logic [15:0] ich;
    logic [15:0] och;

    logic        accept;
    logic        last_word;
    logic [15:0] dim_max;
    logic [15:0] col_nx;
    logic [15:0] row_nx;
    logic [15:0] ich_nx;
    logic [15:0] och_nx;

    assign bus.in_ready = (state == S_LOAD_W) || (state == S_LOAD_B) || (state == S_LOAD_A);
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state != S_IDLE);
    assign dbg_state    = state;

    always_comb begin
        last_word = 1'b0;
        case (state)
            S_LOAD_W: last_word = (word_cnt == W_LAST);
            S_LOAD_B: last_word = (word_cnt == B_LAST);
            S_LOAD_A: last_word = (word_cnt == A_LAST);
            default:  last_word = 1'b0;
        endcase
    end

    // Shared col -> row -> in ch -> out ch ripple; the spatial extent depends on phase.
    always_comb begin
        dim_max = (state == S_LOAD_A) ? D_MAX : K_MAX;
        col_nx  = col + 16'd1;
        row_nx  = row;
        ich_nx  = ich;
        och_nx  = och;
        if (col == dim_max) begin
            col_nx = '0;
            row_nx = row + 16'd1;
            if (row == dim_max) begin
                row_nx = '0;
                ich_nx = ich + 16'd1;
                if (ich == I_MAX) begin
                    ich_nx = '0;
                    och_nx = och + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= S_IDLE;
            word_cnt               <= '0;
            col                    <= '0;
            row                    <= '0;
            ich                    <= '0;
            och                    <= '0;
            bus.write_data         <= '0;
            bus.index3             <= '0;
            bus.index2             <= '0;
            bus.index1             <= '0;
            bus.index0             <= '0;
            bus.want_write_weights <= 1'b0;
            bus.want_write_bias    <= 1'b0;
            bus.want_write_act     <= 1'b0;
            bus.compute            <= 1'b0;
            done                   <= 1'b0;
        end else begin
            bus.want_write_weights <= 1'b0;
            bus.want_write_bias    <= 1'b0;
            bus.want_write_act     <= 1'b0;
            bus.compute            <= 1'b0;
            done                   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD_W;
                        word_cnt <= '0;
                        col      <= '0;
                        row      <= '0;
                        ich      <= '0;
                        och      <= '0;
                    end
                end

                S_LOAD_W, S_LOAD_B, S_LOAD_A: begin
                    if (accept) begin
                        bus.write_data <= bus.in_data;
                        case (state)
                            S_LOAD_W: begin
                                bus.index3             <= och;
                                bus.index2             <= ich;
                                bus.index1             <= row;
                                bus.index0             <= col;
                                bus.want_write_weights <= 1'b1;
                            end
                            S_LOAD_B: begin
                                bus.index3          <= '0;
                                bus.index2          <= '0;
                                bus.index1          <= '0;
                                bus.index0          <= word_cnt;
                                bus.want_write_bias <= 1'b1;
                            end
                            default: begin
                                bus.index3         <= '0;
                                bus.index2         <= ich;
                                bus.index1         <= row;
                                bus.index0         <= col;
                                bus.want_write_act <= 1'b1;
                            end
                        endcase

                        // Phase change happens on the accepting edge so the next word is taken without a bubble.
                        if (last_word) begin
                            word_cnt <= '0;
                            col      <= '0;
                            row      <= '0;
                            ich      <= '0;
                            och      <= '0;
                            case (state)
                                S_LOAD_W: state <= S_LOAD_B;
                                S_LOAD_B: state <= S_LOAD_A;
                                default:  state <= S_FIRE;
                            endcase
                        end else begin
                            word_cnt <= word_cnt + 16'd1;
                            col      <= col_nx;
                            row      <= row_nx;
                            ich      <= ich_nx;
                            och      <= och_nx;
                        end
                    end
                end

                // FIRE exists so compute lands strictly after the final activation write.
                S_FIRE: begin
                    state       <= S_WAIT;
                    bus.compute <= 1'b1;
                end

                S_WAIT: begin
                    if (bus.layer_done) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end

                S_DONE: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_loader.sv
// Randomized scoreboard bench for layer_loader: a small and a degenerate-size instance,
// expected writes derived from index arithmetic over the load order.
module tb_layer_loader;

    localparam int NI = 1, ID = 4, NO = 2, KD = 2;
    localparam int NW = NO * NI * KD * KD;
    localparam int NB = NO;
    localparam int TOTAL = NW + NB + NI * ID * ID;
    localparam int BNI = 1, BID = 2, BNO = 1, BKD = 1;
    localparam int BTOTAL = BNO * BNI * BKD * BKD + BNO + BNI * BID * BID;
    localparam int REC_W = 131;
    localparam logic [2:0] K_W = 3'd1, K_B = 3'd2, K_A = 3'd3, K_CMP = 3'd4, K_DONE = 3'd5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, start_b;
    logic       busy, done, busy_b, done_b;
    logic [2:0] dbg_state, dbg_state_b;

    layer_loader_if #(.DATA_SIZE(64)) bus ();
    layer_loader_if #(.DATA_SIZE(64)) bus_b ();

    layer_loader #(.DATA_SIZE(64), .NUM_INPUTS(NI), .INPUT_DIM(ID),
                   .NUM_OUTPUTS(NO), .KERNEL_DIM(KD)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    layer_loader #(.DATA_SIZE(64), .NUM_INPUTS(BNI), .INPUT_DIM(BID),
                   .NUM_OUTPUTS(BNO), .KERNEL_DIM(BKD)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bus(bus_b.slave),
        .busy(busy_b), .done(done_b), .dbg_state(dbg_state_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_w_cyc = -10;
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] exp_b[$];
    logic [63:0] word_arr[TOTAL];

    // Record: {kind, index3, index2, index1, index0, data}
    function automatic logic [REC_W-1:0] model(input int k, input logic [63:0] d,
                                               input int ni, input int id, input int no, input int kd);
        int nw = no * ni * kd * kd;
        int a;
        logic [15:0] i3 = '0, i2 = '0, i1 = '0, i0 = '0;
        logic [2:0] kind;
        if (k < nw) begin
            kind = K_W;
            i0 = 16'(k % kd);
            i1 = 16'((k / kd) % kd);
            i2 = 16'((k / (kd * kd)) % ni);
            i3 = 16'(k / (kd * kd * ni));
        end else if (k < nw + no) begin
            kind = K_B;
            i0 = 16'(k - nw);
        end else begin
            kind = K_A;
            a  = k - nw - no;
            i0 = 16'(a % id);
            i1 = 16'((a / id) % id);
            i2 = 16'(a / (id * id));
        end
        return {kind, i3, i2, i1, i0, d};
    endfunction

    function automatic logic [REC_W-1:0] act_rec(input logic w, input logic b, input logic a,
                                                 input logic c, input logic dn,
                                                 input logic [15:0] i3, input logic [15:0] i2,
                                                 input logic [15:0] i1, input logic [15:0] i0,
                                                 input logic [63:0] d);
        logic [2:0] kind;
        kind = w ? K_W : b ? K_B : a ? K_A : c ? K_CMP : dn ? K_DONE : 3'd0;
        if (kind >= K_CMP) return {kind, 128'b0};
        return {kind, i3, i2, i1, i0, d};
    endfunction

    task automatic check_eq(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_unexpected(input string name, input logic [REC_W-1:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event %h expected none", name, act);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe, compute or done pulse consumes one expected record.
    always @(negedge clk) begin
        if (bus.want_write_weights || bus.want_write_bias || bus.want_write_act || bus.compute || done) begin
            check_eq("main one event", REC_W'($countones({bus.want_write_weights, bus.want_write_bias,
                     bus.want_write_act, bus.compute, done})), REC_W'(1));
            if (exp_q.size() == 0)
                flag_unexpected("main event", act_rec(bus.want_write_weights, bus.want_write_bias,
                    bus.want_write_act, bus.compute, done, bus.index3, bus.index2, bus.index1,
                    bus.index0, bus.write_data));
            else
                check_eq("main event", act_rec(bus.want_write_weights, bus.want_write_bias,
                    bus.want_write_act, bus.compute, done, bus.index3, bus.index2, bus.index1,
                    bus.index0, bus.write_data), exp_q.pop_front());
            if (bus.want_write_act) last_w_cyc <= cyc;
            if (bus.compute) check_eq("compute gap", REC_W'(cyc - last_w_cyc), REC_W'(1));
        end
        if (bus_b.want_write_weights || bus_b.want_write_bias || bus_b.want_write_act || bus_b.compute || done_b) begin
            if (exp_b.size() == 0)
                flag_unexpected("bound event", act_rec(bus_b.want_write_weights, bus_b.want_write_bias,
                    bus_b.want_write_act, bus_b.compute, done_b, bus_b.index3, bus_b.index2,
                    bus_b.index1, bus_b.index0, bus_b.write_data));
            else
                check_eq("bound event", act_rec(bus_b.want_write_weights, bus_b.want_write_bias,
                    bus_b.want_write_act, bus_b.compute, done_b, bus_b.index3, bus_b.index2,
                    bus_b.index1, bus_b.index0, bus_b.write_data), exp_b.pop_front());
        end
    end

    task automatic check_idle(input string name);
        check_eq({name, " ctrl"}, REC_W'({bus.in_ready, bus.want_write_weights, bus.want_write_bias,
                 bus.want_write_act, bus.compute, busy, done}), '0);
        check_eq({name, " data"}, REC_W'({bus.index3, bus.index2, bus.index1, bus.index0,
                 bus.write_data}), '0);
    endtask

    task automatic fill_words(input bit directed);
        for (int i = 0; i < TOTAL; i++)
            word_arr[i] = directed ? 64'(i + 1) : {$urandom, $urandom};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random valid plus stray start/layer_done
    task automatic do_stream(input int mode, input bit hold_start, input int stop_at);
        int  k = 0;
        int  budget = 0;
        bit  v;
        bit  tog = 1'b0;
        while (k < stop_at && budget < 400) begin
            case (mode)
                0: v = 1'b1;
                1: begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = word_arr[k];
            if (mode == 2) begin
                bus.layer_done = (k < NW);
                start          = (k >= NW + NB);
            end
            if (v && bus.in_ready) begin
                exp_q.push_back(model(k, word_arr[k], NI, ID, NO, KD));
                k++;
            end
            @(posedge clk); #1;
            budget++;
        end
        bus.in_valid   = 1'b0;
        bus.layer_done = 1'b0;
        start          = 1'b0;
        check_eq("stream words", REC_W'(k), REC_W'(stop_at));
        if (stop_at < TOTAL) return;

        exp_q.push_back({K_CMP, 128'b0});
        budget = 0;
        while (!bus.compute && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check_eq("compute seen", REC_W'(bus.compute), REC_W'(1));
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            @(posedge clk); #1;
        end
        bus.layer_done = 1'b1;
        exp_q.push_back({K_DONE, 128'b0});
        if (hold_start) start = 1'b1;
        @(posedge clk); #1;
        bus.layer_done = 1'b0;
        check_eq("done pulse", REC_W'({done, busy}), REC_W'(2'b11));
        @(posedge clk); #1;
        check_eq("idle after done", REC_W'({done, busy, bus.in_ready}), '0);
    endtask

    task automatic boundary_run();
        int k = 0;
        int budget = 0;
        logic [63:0] bd;
        bd = {$urandom, $urandom};
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        while (k < BTOTAL && budget < 100) begin
            bus_b.in_valid = 1'($urandom_range(0, 1));
            bus_b.in_data  = bd;
            if (bus_b.in_valid && bus_b.in_ready) begin
                exp_b.push_back(model(k, bd, BNI, BID, BNO, BKD));
                bd = {$urandom, $urandom};
                k++;
            end
            @(posedge clk); #1;
            budget++;
        end
        bus_b.in_valid = 1'b0;
        check_eq("bound words", REC_W'(k), REC_W'(BTOTAL));
        exp_b.push_back({K_CMP, 128'b0});
        budget = 0;
        while (!bus_b.compute && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check_eq("bound compute", REC_W'(bus_b.compute), REC_W'(1));
        bus_b.layer_done = 1'b1;
        exp_b.push_back({K_DONE, 128'b0});
        @(posedge clk); #1;
        bus_b.layer_done = 1'b0;
        check_eq("bound done", REC_W'({done_b, busy_b}), REC_W'(2'b11));
        @(posedge clk); #1;
        check_eq("bound idle", REC_W'({done_b, busy_b}), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b0;
        start            = 1'b0;
        start_b          = 1'b0;
        bus.in_data      = '0;
        bus.in_valid     = 1'b0;
        bus.layer_done   = 1'b0;
        bus_b.in_data    = '0;
        bus_b.in_valid   = 1'b0;
        bus_b.layer_done = 1'b0;

        #3;
        check_idle("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check_idle("post reset");

        // Directed stream of 1..26, no stalls.
        fill_words(1'b1);
        pulse_start();
        do_stream(0, 1'b0, TOTAL);

        // Every-other-cycle stalls.
        fill_words(1'b0);
        pulse_start();
        do_stream(1, 1'b0, TOTAL);

        // Random stalls with stray start during LOAD_A and layer_done during LOAD_W.
        fill_words(1'b0);
        pulse_start();
        do_stream(2, 1'b0, TOTAL);

        // Reset after 12 words, then make sure nothing happens without a new start.
        fill_words(1'b0);
        pulse_start();
        do_stream(0, 1'b0, 12);
        reset = 1'b0;
        #2;
        check_idle("mid reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = {$urandom, $urandom};
        repeat (5) @(posedge clk);
        #1;
        check_idle("after reset");
        bus.in_valid = 1'b0;

        fill_words(1'b0);
        pulse_start();
        do_stream(0, 1'b0, TOTAL);

        // Back-to-back: start held through DONE.
        fill_words(1'b0);
        pulse_start();
        do_stream(0, 1'b1, TOTAL);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("b2b restart", REC_W'({busy, bus.in_ready}), REC_W'(2'b11));
        do_stream(1, 1'b0, TOTAL);

        boundary_run();

        repeat (3) @(posedge clk);
        #1;
        check_eq("main queue empty", REC_W'(exp_q.size()), '0);
        check_eq("bound queue empty", REC_W'(exp_b.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
